lia_sweep_controller: RTL and testbench
=======================================

LIA_SWEEP_CONTROLLER -- requirements
Module: lia_sweep_controller

Interface
REQ-001 Parameter CLR_CYCLES, default 4, is the number of cycles lia_clr is held per sweep point (legal range 1..255).
REQ-002 Parameter IDX_W, default 16, is the width of point count and index.
REQ-003 Port clk, input, 1, is the single clock for all logic.
REQ-004 Port rst, input, 1, is the reset: one clock, synchronous, active-high.
REQ-005 Port start, input, 1, is a sweep start pulse.
REQ-006 Port abort, input, 1, is a sweep abort level/pulse.
REQ-007 Port period_start, input, config_reg_width, is the first point's period.
REQ-008 Port period_step, input, config_reg_width, is the per-point period increment.
REQ-009 Port num_points, input, IDX_W, is the number of points to measure.
REQ-010 Port settle_cycles, input, 32, is the filter settle wait per point.
REQ-011 Ports lia_i and lia_q, input, 2*word_width each, carry the lock-in I/Q outputs.
REQ-012 Port lia_period, output, config_reg_width, drives the lock-in period.
REQ-013 Port lia_clr, output, 1, is the active-high lock-in filter clear.
REQ-014 Ports res_valid (output, 1) and res_ready (input, 1) form the result handshake.
REQ-015 Ports res_i and res_q (output, 2*word_width), res_period (output, config_reg_width) and res_index (output, IDX_W) form the result payload.
REQ-016 Port busy (output, 1) is high when not IDLE; port done (output, 1) is a one-cycle sweep-complete pulse.

Function
REQ-017 The FSM SHALL use states IDLE, CLEAR, SETTLE, CAPTURE, OUTPUT and FINISH.
REQ-018 In IDLE, start SHALL latch period_step and num_points, load the current period from period_start, clear the index and enter CLEAR next cycle; start outside IDLE is ignored.
REQ-019 start with num_points=0 SHALL go directly to FINISH.
REQ-020 CLEAR SHALL assert lia_clr for exactly CLR_CYCLES cycles with lia_period equal to the current period, then enter SETTLE.
REQ-021 SETTLE SHALL remain for exactly settle_cycles cycles, sampled on SETTLE entry (0 means one cycle), then enter CAPTURE.
REQ-022 CAPTURE SHALL register lia_i, lia_q, the current period and the index into res_* in one cycle, then enter OUTPUT.
REQ-023 In OUTPUT, res_valid SHALL be high and res_* stable until the cycle with res_valid&res_ready; res_ready may be high early or constantly.
REQ-024 On transfer, index SHALL increment; if the new index equals num_points, go to FINISH, else period += period_step (modulo 2^config_reg_width, wrap allowed) and go to CLEAR.
REQ-025 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-026 lia_period SHALL hold its last value in IDLE and outside sweeps.
REQ-027 abort in any non-IDLE state SHALL force IDLE next cycle, deassert res_valid and lia_clr, and suppress done; abort has priority over a same-cycle transfer (the consumer may still count that beat).
REQ-028 With the default, minimum per-point latency is CLR_CYCLES+settle_cycles+2 cycles (settle_cycles≥1).

Reset
REQ-029 rst SHALL force IDLE and set lia_period=0, lia_clr=0, res_valid=0, res_*=0, busy=0, done=0, with index and counters cleared; rst overrides start and abort.

Structure
REQ-030 word_width, config_reg_width and the FSM state enum SHALL live in opo_package.
REQ-031 The sole natural sub-module is a loadable down-counter, lia_sweep_timer, shared by CLEAR and SETTLE; everything else is inline.

Verification
REQ-032 Scenario: start with period_start=1000, step=100, num_points=3, settle=50, res_ready=1 -> three results with period 1000/1100/1200 and index 0/1/2, then one done pulse.
REQ-033 Scenario: hold res_ready=0 for 20 cycles in OUTPUT -> res_valid and res_* stay constant, no progress, lia_clr stays low.
REQ-034 Scenario: num_points=0 -> done pulse within 2 cycles of start, res_valid never asserts, lia_period unchanged.
REQ-035 Scenario: abort mid-SETTLE of point 1 -> busy low next cycle, no done, and a later start restarts from index 0 at period_start.
REQ-036 Scenario: period_start=0xFFFFFFF0, step=0x20 (config_reg_width=32), num_points=2 -> second res_period equals 0x00000010.
REQ-037 Scenario: assert rst during OUTPUT -> all outputs zero the next cycle, and start is ignored in the rst cycle.

Source files
------------

// File: rtl/opo_package.sv
// -----------------------------------------------------------------------------
// opo_package
// Shared constants and types for the lock-in sweep controller slice.
//   word_width       : lock-in sample word width (I/Q ports are 2*word_width)
//   config_reg_width : width of period configuration registers
//   sweep_state_e    : sweep controller FSM states
// -----------------------------------------------------------------------------
package opo_package;

  localparam int word_width       = 16;
  localparam int config_reg_width = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    CAPTURE,
    OUTPUT,
    FINISH
  } sweep_state_e;

endpackage : opo_package

// File: rtl/lia_sweep_controller_if.sv
// -----------------------------------------------------------------------------
// lia_sweep_controller_if
// Result handshake bundle between the sweep controller and its consumer.
//   res_valid  : result available (master -> slave)
//   res_ready  : consumer accepts result (slave -> master)
//   res_i/res_q: captured lock-in I/Q, 2*word_width bits each
//   res_period : lock-in period used for this point
//   res_index  : sweep point index, IDX_W bits
// -----------------------------------------------------------------------------
interface lia_sweep_controller_if #(
  parameter int IDX_W = 16
);
  import opo_package::*;

  logic                          res_valid;
  logic                          res_ready;
  logic [2*word_width-1:0]       res_i;
  logic [2*word_width-1:0]       res_q;
  logic [config_reg_width-1:0]   res_period;
  logic [IDX_W-1:0]              res_index;

  modport master (
    output res_valid, res_i, res_q, res_period, res_index,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_i, res_q, res_period, res_index,
    output res_ready
  );

endinterface : lia_sweep_controller_if

// File: rtl/lia_sweep_timer.sv
// -----------------------------------------------------------------------------
// lia_sweep_timer
// Loadable down-counter shared by the CLEAR and SETTLE phases. Loading N makes
// zero_o rise after N further cycles, so a phase that lasts K cycles is
// entered with a load value of K-1.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load load_val_i on the next edge (has priority over count)
//   load_val_i : value to load
//   zero_o     : counter has reached zero (saturates there)
// -----------------------------------------------------------------------------
module lia_sweep_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule : lia_sweep_timer

// File: rtl/lia_sweep_controller.sv
// -----------------------------------------------------------------------------
// lia_sweep_controller
// Steps a lock-in amplifier through a list of periods. For each point the
// filter is cleared, allowed to settle, and the I/Q outputs are captured and
// offered on a valid/ready result port.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a sweep (IDLE only) / cancel a running sweep
//   period_start    : first point's period
//   period_step     : per-point period increment (wraps)
//   num_points      : number of points (0 finishes immediately)
//   settle_cycles   : settle wait per point, 0 behaves as 1
//   lia_i, lia_q    : lock-in I/Q inputs
//   lia_period      : period driven to the lock-in (holds between sweeps)
//   lia_clr         : lock-in filter clear, high for CLR_CYCLES per point
//   busy, done      : not IDLE / one-cycle sweep-complete pulse
//   res             : result handshake (master side)
// -----------------------------------------------------------------------------
module lia_sweep_controller
  import opo_package::*;
#(
  parameter int CLR_CYCLES = 4,
  parameter int IDX_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [config_reg_width-1:0]   period_start,
  input  logic [config_reg_width-1:0]   period_step,
  input  logic [IDX_W-1:0]              num_points,
  input  logic [31:0]                   settle_cycles,
  input  logic [2*word_width-1:0]       lia_i,
  input  logic [2*word_width-1:0]       lia_q,
  output logic [config_reg_width-1:0]   lia_period,
  output logic                          lia_clr,
  output logic                          busy,
  output logic                          done,
  lia_sweep_controller_if.master        res
);

  localparam int               TMR_W    = 32;
  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYCLES - 1);

  sweep_state_e                state_q, state_d;
  logic [config_reg_width-1:0] period_q, period_d;
  logic [config_reg_width-1:0] step_q, step_d;
  logic [IDX_W-1:0]            npts_q, npts_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [IDX_W-1:0]            index_inc;

  logic [2*word_width-1:0]     cap_i_q, cap_q_q;
  logic [config_reg_width-1:0] cap_period_q;
  logic [IDX_W-1:0]            cap_index_q;

  logic                        tmr_load;
  logic [TMR_W-1:0]            tmr_val;
  logic                        tmr_zero;

  lia_sweep_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign index_inc = index_q + 1'b1;

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    step_d   = step_q;
    npts_d   = npts_q;
    index_d  = index_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          step_d  = period_step;
          npts_d  = num_points;
          index_d = '0;
          // An empty sweep leaves lia_period untouched.
          if (num_points == '0) begin
            state_d = FINISH;
          end else begin
            period_d = period_start;
            state_d  = CLEAR;
            tmr_load = 1'b1;
            tmr_val  = CLR_LOAD;
          end
        end
      end

      CLEAR: begin
        if (tmr_zero) begin
          // settle_cycles is sampled here so it applies from SETTLE entry.
          state_d  = SETTLE;
          tmr_load = 1'b1;
          tmr_val  = (settle_cycles == '0) ? '0 : settle_cycles - 32'd1;
        end
      end

      SETTLE: begin
        if (tmr_zero) state_d = CAPTURE;
      end

      CAPTURE: state_d = OUTPUT;

      OUTPUT: begin
        if (res.res_ready) begin
          index_d = index_inc;
          if (index_inc == npts_q) begin
            state_d = FINISH;
          end else begin
            period_d = period_q + step_q;
            state_d  = CLEAR;
            tmr_load = 1'b1;
            tmr_val  = CLR_LOAD;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Abort wins over a same-cycle transfer: the sweep position is frozen.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      period_d = period_q;
      index_d  = index_q;
      tmr_load = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and ordering between blocks cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      period_q     <= '0;
      step_q       <= '0;
      npts_q       <= '0;
      index_q      <= '0;
      // NOTE: the result payload is reset as well, since it is visible on the
      // port and consumers expect zeros after rst rather than stale data.
      cap_i_q      <= '0;
      cap_q_q      <= '0;
      cap_period_q <= '0;
      cap_index_q  <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      step_q   <= step_d;
      npts_q   <= npts_d;
      index_q  <= index_d;
      if (state_q == CAPTURE) begin
        cap_i_q      <= lia_i;
        cap_q_q      <= lia_q;
        cap_period_q <= period_q;
        cap_index_q  <= index_q;
      end
    end
  end

  assign lia_period     = period_q;
  assign lia_clr        = (state_q == CLEAR);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);

  assign res.res_valid  = (state_q == OUTPUT);
  assign res.res_i      = cap_i_q;
  assign res.res_q      = cap_q_q;
  assign res.res_period = cap_period_q;
  assign res.res_index  = cap_index_q;

endmodule : lia_sweep_controller

// File: tb/tb_lia_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_lia_sweep_controller
// Self-checking bench: stimulus pushes the expected result list of each sweep
// into a queue; an independent monitor pops and compares on every transfer and
// also checks clear width, settle gap, payload stability and done width.
// The lock-in model returns I/Q as a fixed function of the applied period.
// -----------------------------------------------------------------------------
module tb_lia_sweep_controller;
  import opo_package::*;

  localparam int CLR_CYCLES = 4;
  localparam int IDX_W      = 16;
  localparam int CW         = config_reg_width;
  localparam int DW         = 2 * word_width;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [CW-1:0]     period_start, period_step;
  logic [IDX_W-1:0]  num_points;
  logic [31:0]       settle_cycles;
  logic [DW-1:0]     lia_i, lia_q;
  logic [CW-1:0]     lia_period;
  logic              lia_clr, busy, done;

  lia_sweep_controller_if #(.IDX_W(IDX_W)) res_if ();

  lia_sweep_controller #(
    .CLR_CYCLES (CLR_CYCLES),
    .IDX_W      (IDX_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .period_start  (period_start),
    .period_step   (period_step),
    .num_points    (num_points),
    .settle_cycles (settle_cycles),
    .lia_i         (lia_i),
    .lia_q         (lia_q),
    .lia_period    (lia_period),
    .lia_clr       (lia_clr),
    .busy          (busy),
    .done          (done),
    .res           (res_if.master)
  );

  always #5 clk = ~clk;

  // Lock-in stand-in: output depends only on the period it is driven with.
  function automatic logic [DW-1:0] sig_i(input logic [CW-1:0] p);
    return DW'(p ^ 32'hA5A5_1234);
  endfunction

  function automatic logic [DW-1:0] sig_q(input logic [CW-1:0] p);
    return DW'(p * 32'd7 + 32'd3);
  endfunction

  assign lia_i = sig_i(lia_period);
  assign lia_q = sig_q(lia_period);

  typedef struct {
    logic [DW-1:0]    i;
    logic [DW-1:0]    q;
    logic [CW-1:0]    period;
    logic [IDX_W-1:0] index;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int done_cnt   = 0;
  int xfer_cnt   = 0;
  int valid_cnt  = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int settle_cur = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready driver.
  initial begin
    res_if.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       res_if.res_ready = 1'b1;
        1:       res_if.res_ready = 1'($urandom_range(0, 1));
        default: res_if.res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops and protocol/timing checks.
  initial begin
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic           prev_done  = 1'b0;
    logic [DW-1:0]  p_i = '0, p_q = '0;
    logic [CW-1:0]  p_per = '0;
    logic [IDX_W-1:0] p_idx = '0;
    int             clr_run = 0;
    int             gap = 0;
    bit             in_gap = 1'b0;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (res_if.res_valid) begin
        if (!prev_valid) valid_cnt++;
        check("clr_low_in_output", 64'(lia_clr), 64'd0);
        if (prev_valid && !prev_ready) begin
          check("stable_i",      64'(res_if.res_i),      64'(p_i));
          check("stable_q",      64'(res_if.res_q),      64'(p_q));
          check("stable_period", 64'(res_if.res_period), 64'(p_per));
          check("stable_index",  64'(res_if.res_index),  64'(p_idx));
        end
        if (res_if.res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("res_i",      64'(res_if.res_i),      64'(e.i));
            check("res_q",      64'(res_if.res_q),      64'(e.q));
            check("res_period", 64'(res_if.res_period), 64'(e.period));
            check("res_index",  64'(res_if.res_index),  64'(e.index));
          end
          xfer_cnt++;
        end
      end

      if (lia_clr) begin
        clr_run++;
      end else begin
        if (clr_run != 0) begin
          if (busy) check("clr_cycles", 64'(clr_run), 64'(CLR_CYCLES));
          in_gap = busy;
          gap    = 0;
        end
        clr_run = 0;
      end

      if (in_gap) begin
        if (!busy) begin
          in_gap = 1'b0;
        end else if (res_if.res_valid) begin
          check("settle_gap", 64'(gap), 64'(((settle_cur == 0) ? 1 : settle_cur) + 1));
          in_gap = 1'b0;
        end else begin
          gap++;
        end
      end

      if (done) begin
        check("done_one_cycle", 64'(prev_done), 64'd0);
        done_cnt++;
      end

      prev_valid = res_if.res_valid;
      prev_ready = res_if.res_ready;
      prev_done  = done;
      p_i   = res_if.res_i;
      p_q   = res_if.res_q;
      p_per = res_if.res_period;
      p_idx = res_if.res_index;
    end
  end

  task automatic start_sweep(input logic [CW-1:0] ps, input logic [CW-1:0] st,
                             input int n, input int s);
    exp_t e;
    logic [CW-1:0] p;
    period_start  = ps;
    period_step   = st;
    num_points    = IDX_W'(n);
    settle_cycles = 32'(s);
    settle_cur    = s;
    for (int k = 0; k < n; k++) begin
      p        = ps + st * CW'(k);
      e.i      = sig_i(p);
      e.q      = sig_q(p);
      e.period = p;
      e.index  = IDX_W'(k);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(done), 64'd1);
    check({name, "_all_results"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int c = 0;
    while (!res_if.res_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(res_if.res_valid), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, v0, x0, c;
    int n, s;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    period_start = '0; period_step = '0; num_points = '0; settle_cycles = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_period", 64'(lia_period),        64'd0);
    check("rst_clr",    64'(lia_clr),           64'd0);
    check("rst_valid",  64'(res_if.res_valid),  64'd0);
    check("rst_busy",   64'(busy),              64'd0);
    check("rst_done",   64'(done),              64'd0);
    check("rst_res_i",  64'(res_if.res_i),      64'd0);
    check("rst_res_p",  64'(res_if.res_period), 64'd0);
    check("rst_res_ix", 64'(res_if.res_index),  64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Basic three-point sweep.
    ready_mode = 0;
    start_sweep(32'd1000, 32'd100, 3, 50);
    wait_done(600, "done_basic");
    check("period_hold_after_sweep", 64'(lia_period), 64'd1200);

    // Empty sweep.
    v0 = valid_cnt;
    start_sweep(32'd5555, 32'd1, 0, 5);
    wait_done(2, "done_zero_points");
    check("zero_points_no_valid", 64'(valid_cnt), 64'(v0));
    check("zero_points_period",   64'(lia_period), 64'd1200);

    // Period wrap.
    start_sweep(32'hFFFF_FFF0, 32'h20, 2, 3);
    wait_done(200, "done_wrap");

    // Randomised sweeps with random backpressure.
    ready_mode = 1;
    repeat (4) begin
      n = $urandom_range(1, 4);
      s = $urandom_range(0, 6);
      start_sweep($urandom, $urandom, n, s);
      wait_done(n * 400 + 20, "done_random");
    end

    // Held backpressure in OUTPUT.
    ready_mode = 2;
    start_sweep(32'd2000, 32'd7, 2, 2);
    wait_valid(100, "bp_valid_reached");
    repeat (20) @(negedge clk);
    check("bp_valid_held",  64'(res_if.res_valid),  64'd1);
    check("bp_index",       64'(res_if.res_index),  64'd0);
    check("bp_period",      64'(res_if.res_period), 64'd2000);
    check("bp_clr_low",     64'(lia_clr),           64'd0);
    ready_mode = 0;
    wait_done(200, "done_backpressure");

    // Abort in SETTLE of point 1, then restart.
    d0 = done_cnt;
    x0 = xfer_cnt;
    start_sweep(32'd3000, 32'd50, 3, 20);
    c = 0;
    while (xfer_cnt == x0 && c < 200) begin @(negedge clk); c++; end
    check("abort_first_xfer", 64'(xfer_cnt - x0), 64'd1);
    c = 0;
    while (!lia_clr && c < 20) begin @(negedge clk); c++; end
    c = 0;
    while (lia_clr && c < 20) begin @(negedge clk); c++; end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy_low",  64'(busy),              64'd0);
    check("abort_clr_low",   64'(lia_clr),           64'd0);
    check("abort_valid_low", 64'(res_if.res_valid),  64'd0);
    check("abort_period",    64'(lia_period),        64'd3050);
    exp_q.delete();
    repeat (60) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    start_sweep(32'd3000, 32'd50, 3, 2);
    wait_done(300, "done_after_abort");

    // Reset during OUTPUT with start asserted in the reset cycle.
    ready_mode = 2;
    start_sweep(32'd4000, 32'd1, 2, 1);
    wait_valid(100, "rst_test_valid_reached");
    @(posedge clk);
    #1 begin rst = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    check("mid_rst_period", 64'(lia_period),        64'd0);
    check("mid_rst_valid",  64'(res_if.res_valid),  64'd0);
    check("mid_rst_busy",   64'(busy),              64'd0);
    check("mid_rst_clr",    64'(lia_clr),           64'd0);
    check("mid_rst_res_i",  64'(res_if.res_i),      64'd0);
    check("mid_rst_res_q",  64'(res_if.res_q),      64'd0);
    check("mid_rst_res_p",  64'(res_if.res_period), 64'd0);
    check("mid_rst_res_ix", 64'(res_if.res_index),  64'd0);
    exp_q.delete();
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("mid_rst_start_ignored", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_lia_sweep_controller
